assoc_cache: RTL
================

# assoc_cache

Parametrised N-way set-associative, write-through, read-allocate cache with an integrated miss-handling FSM and a word-serial memory fill port. Sits between the pipeline's memory stage (instruction or data side) and the shared memory arbiter. It generalises the fixed 2-way/64-set/16-bit cache: ways, sets, block size and widths become parameters, LRU becomes true N-way age LRU, and the cache fills itself instead of relying on an external fill controller.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width (word = 2 bytes; address bit 0 ignored)
- SETS, 64, number of sets (power of 2)
- WAYS, 2, associativity (1, 2, 4 or 8)
- WORDS, 8, words per block (power of 2, >= 2)
- Derived: IDX_W = log2(SETS); OFF_W = log2(WORDS)+1; TAG_W = ADDR_W - IDX_W - OFF_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- cpu_req  in  1  request valid; must stay high with stable addr/wen/wdata until cpu_ready
- cpu_wen  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid when cpu_ready & ~cpu_wen
- cpu_ready  out  1  one-cycle completion pulse
- cpu_miss  out  1  high while a fill is in progress
- inv  in  1  invalidate all lines
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_gnt  in  1  memory accepts current request this cycle
- mem_rvalid  in  1  read data return, in issue order
- mem_rdata  in  DATA_W  read data

## Operation
- Address split: tag = addr[ADDR_W-1 -: TAG_W], index = addr[OFF_W +: IDX_W], word = addr[OFF_W-1:1].
- Per line: valid bit, tag, WORDS data words, age (log2 WAYS bits). Hit = any way with valid & tag match; at most one way may match.
- LRU: on an access to way w with age a, every way in the set with age < a increments; w gets 0. Victim = lowest-index invalid way, else the way with age WAYS-1. Ages in a set always form a permutation of 0..WAYS-1.
- FSM states IDLE, FILL, WRITE.
- IDLE: inv -> clear every valid bit, no request served that cycle. Else cpu_req & ~cpu_wen & hit -> cpu_ready = 1 and cpu_rdata = hit word combinationally, LRU updated at edge. cpu_req & ~cpu_wen & miss -> FILL. cpu_req & cpu_wen -> WRITE.
- FILL: on entry latch victim way and block base (addr with offset zeroed); clear victim valid. Issue counter drives mem_addr = base + 2*k, mem_we = 0, mem_req while k < WORDS; k increments on mem_gnt. Return counter writes mem_rdata into victim word r on each mem_rvalid. After return WORDS-1: write tag, set valid, touch LRU, go IDLE; the still-held request then hits next cycle.
- WRITE: mem_req = 1, mem_we = 1, mem_addr = cpu_addr, mem_wdata = cpu_wdata. On mem_gnt: cpu_ready = 1; if hit, update that word and LRU; go IDLE. Write miss does not allocate.
- inv outside IDLE is ignored. mem_rvalid with no outstanding fill read is ignored.

## Timing
- Reset: all valid bits 0, ages of way i = i in every set, FSM = IDLE, counters 0; cpu_ready, cpu_miss, mem_req, mem_we = 0; cpu_rdata, mem_addr, mem_wdata = 0.
- Reset mid-fill or mid-write abandons the operation; memory responses arriving after reset are ignored.
- Read hit: 0 extra cycles (ready in the request cycle).
- Read miss: 1 cycle into FILL, plus WORDS grants, plus return latency, plus 1 cycle in IDLE for the hit. cpu_miss rises the cycle after the miss and falls when the FSM returns to IDLE.
- Store: ready in the cycle mem_gnt is high, at least 1 cycle after the request.
- Issue and return overlap; up to WORDS reads may be outstanding.

## Test plan
- Reset then load 0x1234 -> cpu_miss = 1, 8 reads at 0x1230..0x123E; return D0..D7; next cycle cpu_ready = 1, cpu_rdata = D2.
- Repeat load 0x1234 -> cpu_ready = 1 in the same cycle, no mem_req.
- WAYS=2: fill tags A, B into set 3, touch A, then miss on C in set 3 -> B's way is refilled; A still hits and B misses.
- Store 0xBEEF to 0x1236 (hit) with mem_gnt delayed 3 cycles -> ready on the grant cycle, mem_we = 1; a following load returns 0xBEEF. Store to an unmapped address -> memory write only; a following load misses.
- inv in IDLE after fills -> all subsequent loads miss.
- rst asserted after 4 of 8 returns -> outputs at reset values immediately; the set is invalid; a late mem_rvalid changes nothing.

Source files
------------

// File: rtl/assoc_cache_if.sv
// Request bus from the pipeline plus fill/write bus toward the memory arbiter.
// The slave modport is the cache's view; master is the surrounding system.
interface assoc_cache_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_miss;
    logic              inv;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wen, cpu_addr, cpu_wdata, inv,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output cpu_rdata, cpu_ready, cpu_miss,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_wen, cpu_addr, cpu_wdata, inv,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  cpu_rdata, cpu_ready, cpu_miss,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative, write-through, read-allocate cache with true age-based
// LRU replacement and a self-contained word-serial block fill engine.
module assoc_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int WORDS  = 8
) (
    input  logic         clk,
    input  logic         rst,
    assoc_cache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WRD_W = $clog2(WORDS);
    localparam int OFF_W = WRD_W + 1;
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W = WRD_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [WAY_W-1:0]  r_age   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS][WORDS];

    logic [ADDR_W-1:0] r_fillBase;
    logic [WAY_W-1:0]  r_victim;
    logic [CNT_W-1:0]  r_issueCnt;
    logic [CNT_W-1:0]  r_retCnt;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [WRD_W-1:0]  w_word;
    logic [IDX_W-1:0]  w_fillIdx;
    logic [TAG_W-1:0]  w_fillTag;
    logic [WAYS-1:0]   w_hitVec;
    logic [WAY_W-1:0]  w_hitWay;
    logic              w_hit;
    logic [DATA_W-1:0] w_hitData;
    logic [WAY_W-1:0]  w_lruWay;
    logic [WAY_W-1:0]  w_invWay;
    logic              w_anyInv;
    logic [WAY_W-1:0]  w_victim;

    logic              w_lookup;
    logic              w_readHit;
    logic              w_startFill;
    logic              w_invAll;
    logic              w_issue;
    logic              w_retFire;
    logic              w_fillDone;
    logic              w_writeDone;
    logic              w_writeHit;
    logic              w_touchEn;
    logic [IDX_W-1:0]  w_touchIdx;
    logic [WAY_W-1:0]  w_touchWay;
    logic [WAY_W-1:0]  w_touchAge;

    assign w_tag     = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_idx     = bus.cpu_addr[OFF_W +: IDX_W];
    assign w_word    = bus.cpu_addr[OFF_W-1:1];
    assign w_fillIdx = r_fillBase[OFF_W +: IDX_W];
    assign w_fillTag = r_fillBase[ADDR_W-1 -: TAG_W];

    always_comb begin
        w_hitVec = '0;
        w_hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hitVec[w] = 1'b1;
                w_hitWay    = WAY_W'(w);
            end
        end
    end

    assign w_hit     = |w_hitVec;
    assign w_hitData = r_data[w_idx][w_hitWay][w_word];

    // Victim: lowest-index invalid way wins, otherwise the oldest way.
    always_comb begin
        w_lruWay = '0;
        w_invWay = '0;
        w_anyInv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_lruWay = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_anyInv = 1'b1;
                w_invWay = WAY_W'(w);
            end
        end
        w_victim = w_anyInv ? w_invWay : w_lruWay;
    end

    assign w_invAll    = (r_state == IDLE) && bus.inv;
    assign w_lookup    = (r_state == IDLE) && !bus.inv && bus.cpu_req;
    assign w_readHit   = w_lookup && !bus.cpu_wen && w_hit;
    assign w_startFill = w_lookup && !bus.cpu_wen && !w_hit;
    assign w_issue     = (r_state == FILL) && (r_issueCnt < CNT_W'(WORDS));
    assign w_retFire   = (r_state == FILL) && bus.mem_rvalid && (r_retCnt < r_issueCnt);
    assign w_fillDone  = w_retFire && (r_retCnt == CNT_W'(WORDS - 1));
    assign w_writeDone = (r_state == WRITE) && bus.mem_gnt;
    assign w_writeHit  = w_writeDone && w_hit;

    assign w_touchEn  = w_readHit || w_writeHit || w_fillDone;
    assign w_touchIdx = w_fillDone ? w_fillIdx : w_idx;
    assign w_touchWay = w_fillDone ? r_victim : w_hitWay;
    assign w_touchAge = r_age[w_touchIdx][w_touchWay];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_lookup && bus.cpu_wen) w_nextState = WRITE;
                else if (w_startFill)        w_nextState = FILL;
            end
            FILL:    if (w_fillDone)  w_nextState = IDLE;
            WRITE:   if (w_writeDone) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_ready = w_readHit || w_writeDone;
        bus.cpu_rdata = w_readHit ? w_hitData : '0;
        bus.cpu_miss  = (r_state == FILL);
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            FILL: begin
                if (w_issue) begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = r_fillBase | ADDR_W'({r_issueCnt[WRD_W-1:0], 1'b0});
                end
            end
            WRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
            end
            default: ;
        endcase
    end

    // Ages younger than the touched way grow older; the touched way becomes youngest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= WAY_W'(w);
        end else if (w_touchEn) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == w_touchWay)
                    r_age[w_touchIdx][w] <= '0;
                else if (r_age[w_touchIdx][w] < w_touchAge)
                    r_age[w_touchIdx][w] <= r_age[w_touchIdx][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else if (w_invAll) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else if (w_startFill) begin
            r_valid[w_idx][w_victim] <= 1'b0;
        end else if (w_fillDone) begin
            r_valid[w_fillIdx][r_victim] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fillBase <= '0;
            r_victim   <= '0;
            r_issueCnt <= '0;
            r_retCnt   <= '0;
        end else if (w_startFill) begin
            r_fillBase <= {bus.cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            r_victim   <= w_victim;
            r_issueCnt <= '0;
            r_retCnt   <= '0;
        end else begin
            if (w_issue && bus.mem_gnt) r_issueCnt <= r_issueCnt + 1'b1;
            if (w_retFire)              r_retCnt   <= r_retCnt + 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (w_retFire)  r_data[w_fillIdx][r_victim][r_retCnt[WRD_W-1:0]] <= bus.mem_rdata;
        if (w_fillDone) r_tag[w_fillIdx][r_victim] <= w_fillTag;
        if (w_writeHit) r_data[w_idx][w_hitWay][w_word] <= bus.cpu_wdata;
    end
endmodule
